// File: rtl/mbist_pkg.sv
// ---------------------------------------------------------------------------
// mbist_pkg
//   Shared types and the March C- element table for the MBIST sequencer.
//   state_t      : sequencer FSM states
//   march_elem_t : one march element (direction, op count, up to two ops)
//   MARCH_CM     : the six March C- elements in execution order
// ---------------------------------------------------------------------------
package mbist_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_OP1   = 3'd2,
    S_OP2   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // dir: 1 = ascending addresses. nops: 1 or 2 memory ops per address.
  // opN_we: 1 = write, 0 = read. opN_val: data background bit (all-0 / all-1).
  typedef struct packed {
    logic       dir;
    logic [1:0] nops;
    logic       op0_we;
    logic       op0_val;
    logic       op1_we;
    logic       op1_val;
  } march_elem_t;

  localparam int NUM_ELEM = 6;

  // E0 any(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0);
  // E5 any(r0). "Any" elements are run ascending.
  localparam march_elem_t MARCH_CM [NUM_ELEM] = '{
    '{dir: 1'b1, nops: 2'd1, op0_we: 1'b1, op0_val: 1'b0, op1_we: 1'b0, op1_val: 1'b0},
    '{dir: 1'b1, nops: 2'd2, op0_we: 1'b0, op0_val: 1'b0, op1_we: 1'b1, op1_val: 1'b1},
    '{dir: 1'b1, nops: 2'd2, op0_we: 1'b0, op0_val: 1'b1, op1_we: 1'b1, op1_val: 1'b0},
    '{dir: 1'b0, nops: 2'd2, op0_we: 1'b0, op0_val: 1'b0, op1_we: 1'b1, op1_val: 1'b1},
    '{dir: 1'b0, nops: 2'd2, op0_we: 1'b0, op0_val: 1'b1, op1_we: 1'b1, op1_val: 1'b0},
    '{dir: 1'b1, nops: 2'd1, op0_we: 1'b0, op0_val: 1'b0, op1_we: 1'b0, op1_val: 1'b0}
  };

  function automatic logic is_last_elem(input logic [2:0] elem);
    return (elem == 3'(NUM_ELEM - 1));
  endfunction

endpackage

// File: rtl/mbist_resp_cmp.sv
// ---------------------------------------------------------------------------
// mbist_resp_cmp
//   Read-response checker. A read issued in cycle N registers its expected
//   background, element index and address; the synchronous RAM returns data
//   in cycle N+1, where the compare is done. The first mismatch of a run is
//   captured into sticky fail/fail_elem/fail_addr.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   clr_i           clear fail record (new run accepted)
//   rd_vld_i        a read is issued this cycle
//   exp_i           expected background bit for that read
//   elem_i, addr_i  element index / address of that read
//   rdata_i         RAM read data (belongs to the previous cycle's read)
//   mismatch_o      first mismatch detected this cycle
//   fail_o, fail_elem_o, fail_addr_o   sticky first-fail record
// ---------------------------------------------------------------------------
module mbist_resp_cmp #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              rd_vld_i,
  input  logic              exp_i,
  input  logic [2:0]        elem_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              mismatch_o,
  output logic              fail_o,
  output logic [2:0]        fail_elem_o,
  output logic [ADDR_W-1:0] fail_addr_o
);

  logic              vld_q;
  logic [DATA_W-1:0] exp_q;
  logic [2:0]        rd_elem_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              fail_q;
  logic [2:0]        fail_elem_q;
  logic [ADDR_W-1:0] fail_addr_q;

  // Once a failure is recorded, later compares are masked so the record
  // always holds the first mismatch.
  assign mismatch_o = vld_q && (rdata_i != exp_q) && !fail_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= 1'b0;
      fail_q      <= 1'b0;
      fail_elem_q <= '0;
      fail_addr_q <= '0;
    end else begin
      vld_q <= rd_vld_i;
      if (clr_i) begin
        fail_q      <= 1'b0;
        fail_elem_q <= '0;
        fail_addr_q <= '0;
      end else if (mismatch_o) begin
        fail_q      <= 1'b1;
        fail_elem_q <= rd_elem_q;
        fail_addr_q <= rd_addr_q;
      end
    end
  end

  // Read context is pure data; it is only consumed when vld_q is set.
  always_ff @(posedge clk) begin
    if (rd_vld_i) begin
      exp_q     <= {DATA_W{exp_i}};
      rd_elem_q <= elem_i;
      rd_addr_q <= addr_i;
    end
  end

  assign fail_o      = fail_q;
  assign fail_elem_o = fail_elem_q;
  assign fail_addr_o = fail_addr_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// mbist_march_ctrl
//   March C- sequencer. Steers an external up/down address counter
//   (cnt_ld/cnt_ud/cnt_cen/cnt_d, reads back cnt_q/cnt_cout), issues the
//   memory ops of each march element and checks read data through
//   mbist_resp_cmp. Reports busy/done and the first failure.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               1-cycle pulse, accepted only when not busy
//   busy, done          run in progress / run finished (level)
//   fail, fail_elem, fail_addr   sticky first-mismatch record
//   cnt_ld, cnt_ud, cnt_cen, cnt_d   address counter controls
//   cnt_q, cnt_cout     counter value (current address) and terminal count
//   mem_cs, mem_we, mem_addr, mem_wdata, mem_rdata   synchronous RAM port
// ---------------------------------------------------------------------------
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              cnt_ld,
  output logic              cnt_ud,
  output logic              cnt_cen,
  output logic [ADDR_W-1:0] cnt_d,
  input  logic [ADDR_W-1:0] cnt_q,
  input  logic              cnt_cout,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t      state_q, state_d;
  logic [2:0]  elem_q, elem_d;
  march_elem_t cur;
  logic        clr;
  logic        adv;
  logic        op_val;
  logic        in_op;
  logic        rd_vld;
  logic        mismatch;

  assign cur = MARCH_CM[elem_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      elem_q  <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    clr       = 1'b0;
    adv       = 1'b0;
    op_val    = 1'b0;
    cnt_ld    = 1'b0;
    cnt_ud    = 1'b0;
    cnt_cen   = 1'b0;
    cnt_d     = '0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          elem_d  = '0;
          clr     = 1'b1;
        end
      end
      S_LOAD: begin
        cnt_ld  = 1'b1;
        cnt_cen = 1'b1;
        cnt_ud  = cur.dir;
        cnt_d   = cur.dir ? '0 : '1;
        state_d = S_OP1;
      end
      S_OP1: begin
        mem_cs    = 1'b1;
        mem_we    = cur.op0_we;
        op_val    = cur.op0_val;
        mem_wdata = {DATA_W{cur.op0_val}};
        cnt_ud    = cur.dir;
        if (cur.nops == 2'd2) state_d = S_OP2;
        else                  adv     = 1'b1;
      end
      S_OP2: begin
        mem_cs    = 1'b1;
        mem_we    = cur.op1_we;
        op_val    = cur.op1_val;
        mem_wdata = {DATA_W{cur.op1_val}};
        cnt_ud    = cur.dir;
        adv       = 1'b1;
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Last op at this address: either step the counter and loop back to
    // OP1, or, at terminal count, move to the next element (or drain).
    if (adv) begin
      if (cnt_cout) begin
        if (is_last_elem(elem_q)) begin
          state_d = S_DRAIN;
        end else begin
          elem_d  = elem_q + 3'd1;
          state_d = S_LOAD;
        end
      end else begin
        cnt_cen = 1'b1;
        state_d = S_OP1;
      end
    end

    // A failing compare aborts the run: the op of this cycle is dropped.
    if (mismatch && busy) begin
      mem_cs  = 1'b0;
      cnt_cen = 1'b0;
      state_d = S_DONE;
    end
  end

  assign busy     = (state_q == S_LOAD) || (state_q == S_OP1) ||
                    (state_q == S_OP2)  || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign in_op    = (state_q == S_OP1) || (state_q == S_OP2);
  assign mem_addr = in_op ? cnt_q : '0;
  assign rd_vld   = mem_cs && !mem_we;

  mbist_resp_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_resp_cmp (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .rd_vld_i    (rd_vld),
    .exp_i       (op_val),
    .elem_i      (elem_q),
    .addr_i      (cnt_q),
    .rdata_i     (mem_rdata),
    .mismatch_o  (mismatch),
    .fail_o      (fail),
    .fail_elem_o (fail_elem),
    .fail_addr_o (fail_addr)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mbist_march_ctrl
//   Directed bench: behavioural up/down counter and synchronous RAM with a
//   single stuck-at bit fault around the March C- sequencer.
// ---------------------------------------------------------------------------
module tb_mbist_march_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done, fail;
  logic [2:0]        fail_elem;
  logic [ADDR_W-1:0] fail_addr;
  logic              cnt_ld, cnt_ud, cnt_cen;
  logic [ADDR_W-1:0] cnt_d, cnt_q;
  logic              cnt_cout;
  logic              mem_cs, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  // Fault injection: when flt_en, reads of flt_addr return bit flt_bit = flt_val.
  bit flt_en  = 1'b0;
  int flt_addr = 0;
  int flt_bit  = 0;
  bit flt_val  = 1'b0;

  always #5 clk = ~clk;

  mbist_march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_elem (fail_elem),
    .fail_addr (fail_addr),
    .cnt_ld    (cnt_ld),
    .cnt_ud    (cnt_ud),
    .cnt_cen   (cnt_cen),
    .cnt_d     (cnt_d),
    .cnt_q     (cnt_q),
    .cnt_cout  (cnt_cout),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Up/down counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt_q <= '0;
    else if (cnt_ld)  cnt_q <= cnt_d;
    else if (cnt_cen) cnt_q <= cnt_ud ? cnt_q + 1'b1 : cnt_q - 1'b1;
  end
  assign cnt_cout = cnt_ud ? (cnt_q == '1) : (cnt_q == '0);

  // Synchronous RAM
  logic [DATA_W-1:0] mem [2**ADDR_W];

  function automatic logic [DATA_W-1:0] faulty(input logic [DATA_W-1:0] d,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = d;
    if (flt_en && (int'(a) == flt_addr)) r[flt_bit] = flt_val;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (mem_cs && mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_cs && !mem_we) mem_rdata     <= faulty(mem[mem_addr], mem_addr);
  end

  logic [30:0] all_outs;
  assign all_outs = {busy, done, fail, fail_elem, fail_addr, cnt_ld, cnt_ud, cnt_cen,
                     cnt_d, mem_cs, mem_we, mem_addr, mem_wdata};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then count busy cycles (sampled on falling edges).
  // Optionally pulse start again at busy cycle pulse_at.
  task automatic run(input int pulse_at, output int cyc,
                     output logic f1, output logic d1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    f1  = fail;
    d1  = done;
    cyc = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      cyc++;
      start = (cyc == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  int   cyc;
  logic f1, d1;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(all_outs), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", 32'(all_outs), 32'd0);

    // 1: fault-free run
    run(0, cyc, f1, d1);
    check("clean_busy_len", cyc, 167);
    check("clean_done", done, 1);
    check("clean_fail", fail, 0);

    // 2: bit0 stuck-at-1 at address 5 -> caught by E1 r0
    flt_en = 1'b1; flt_addr = 5; flt_bit = 0; flt_val = 1'b1;
    run(0, cyc, f1, d1);
    check("sa1_busy_len", cyc, 30);
    check("sa1_done", done, 1);
    check("sa1_fail", fail, 1);
    check("sa1_fail_elem", fail_elem, 1);
    check("sa1_fail_addr", fail_addr, 5);

    // 3: bit7 stuck-at-0 at address 15 -> caught by E2 r1
    flt_en = 1'b1; flt_addr = 15; flt_bit = 7; flt_val = 1'b0;
    run(0, cyc, f1, d1);
    check("sa0_start_clears_fail", f1, 0);
    check("sa0_start_clears_done", d1, 0);
    check("sa0_busy_len", cyc, 83);
    check("sa0_fail", fail, 1);
    check("sa0_fail_elem", fail_elem, 2);
    check("sa0_fail_addr", fail_addr, 15);

    // 4: fault-free, trace element E3
    flt_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (83) @(negedge clk);
    check("e3_load_ld", cnt_ld, 1);
    check("e3_load_cen", cnt_cen, 1);
    check("e3_load_d", cnt_d, 4'hF);
    check("e3_load_ud", cnt_ud, 0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("e3_addr", mem_addr, 15 - i / 2);
      check("e3_we", mem_we, i % 2);
      check("e3_cs", mem_cs, 1);
      check("e3_cen", cnt_cen, ((i % 2 == 1) && (i != 31)) ? 1 : 0);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    check("e3_run_done", done, 1);
    check("e3_run_fail", fail, 0);

    // 5a: start during E2 is ignored
    run(60, cyc, f1, d1);
    check("restart_ignored_len", cyc, 167);
    check("restart_ignored_fail", fail, 0);

    // 5b: reset in the middle of E2
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (59) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_ud", cnt_ud, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", 32'(all_outs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(0, cyc, f1, d1);
    check("post_rst_busy_len", cyc, 167);
    check("post_rst_done", done, 1);
    check("post_rst_fail", fail, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
